// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit. It owns the program counter and reads one 16-bit word at a
// time from synchronous-read instruction memory. It presents that word to the
// controller over a valid/ready handshake and takes branch/jump redirects.
module instr_fetch_unit #(
    parameter int unsigned       ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_en,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_rdata,
    output logic [15:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [15:0]       fetch_count
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic              handshake;

    // The memory address always tracks the PC, so it equals RESET_PC while in reset.
    assign mem_addr = pc;

    // The controller takes the held word only while the fetch unit is presenting it.
    assign handshake = (state == S_HOLD) & instr_valid & instr_ready;

    // The read strobe is issued in FETCH unless fetch is disabled, a redirect is pending,
    // or the unit is in reset.
    always_comb begin
        mem_rd_en = 1'b0;
        if (reset && (state == S_FETCH)) begin
            mem_rd_en = fetch_en & ~redirect_valid;
        end
    end

    // Fetch FSM, PC, held instruction and handshake counter. A redirect wins in every state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_FETCH;
            pc          <= RESET_PC;
            instr       <= 16'h0000;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            fetch_count <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (redirect_valid) begin
                        pc <= redirect_pc;
                    end else if (fetch_en) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (redirect_valid) begin
                        // The word returning this cycle belongs to the abandoned path.
                        pc    <= redirect_pc;
                        state <= S_FETCH;
                    end else begin
                        instr       <= mem_rdata;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        state       <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (handshake) begin
                        // An accepted word counts even if a redirect arrives in the same cycle.
                        fetch_count <= fetch_count + CNT_W'(1);
                        instr_valid <= 1'b0;
                        state       <= S_FETCH;
                        pc          <= redirect_valid ? redirect_pc : pc + ADDR_W'(1);
                    end else if (redirect_valid) begin
                        instr_valid <= 1'b0;
                        pc          <= redirect_pc;
                        state       <= S_FETCH;
                    end
                end
                default: begin
                    state       <= S_FETCH;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit. Directed timing scenarios are followed by a randomized
// phase that is checked against an architectural PC/handshake reference model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_en, instr_ready, redirect_valid;
    logic [15:0] redirect_pc;
    logic        mem_rd_en, instr_valid;
    logic [15:0] mem_addr, mem_rdata, instr, instr_pc, fetch_count;

    logic        mem_rd_en2, instr_valid2;
    logic [15:0] mem_addr2, mem_rdata2, instr2, instr_pc2, fetch_count2;

    logic [15:0] mem [0:65535];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state for the random phase.
    logic [15:0] exp_pc, exp_cnt, h_instr, h_pc;
    logic        held, hs, found;

    always #5 clk = ~clk;

    // Synchronous-read instruction memory, one read port per DUT.
    always_ff @(posedge clk) begin
        if (mem_rd_en)  mem_rdata  <= mem[mem_addr];
        if (mem_rd_en2) mem_rdata2 <= mem[mem_addr2];
    end

    instr_fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
        .clk(clk), .reset(reset), .fetch_en(fetch_en),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .fetch_count(fetch_count)
    );

    instr_fetch_unit #(.ADDR_W(16), .RESET_PC(16'hFFFF)) dut_wrap (
        .clk(clk), .reset(reset), .fetch_en(1'b1),
        .mem_rd_en(mem_rd_en2), .mem_addr(mem_addr2), .mem_rdata(mem_rdata2),
        .instr(instr2), .instr_pc(instr_pc2), .instr_valid(instr_valid2),
        .instr_ready(1'b1), .redirect_valid(1'b0),
        .redirect_pc(16'h0000), .fetch_count(fetch_count2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        mem[0]       = 16'h5103;
        mem[1]       = 16'h0152;
        mem[2]       = 16'hB2FF;
        mem[16'h0010] = 16'h1234;
        mem[16'h0040] = 16'hA5A5;
        mem[16'hFFFF] = 16'h7E57;

        reset = 1'b1;
        fetch_en = 1'b1;
        instr_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 16'h0000;
        #2 reset = 1'b0;

        // Reset values; the read strobe stays low even with fetch_en high.
        smp();
        check("rst_valid",  32'(instr_valid), 32'd0);
        check("rst_instr",  32'(instr),       32'h0);
        check("rst_ipc",    32'(instr_pc),    32'h0);
        check("rst_count",  32'(fetch_count), 32'd0);
        check("rst_rden",   32'(mem_rd_en),   32'd0);
        check("rst_addr",   32'(mem_addr),    32'h0);
        check("rst_rden2",  32'(mem_rd_en2),  32'd0);
        check("rst_addr2",  32'(mem_addr2),   32'hFFFF);

        next();
        reset = 1'b1;

        // Back-to-back fetch: one instruction every 3 cycles, valid 2 cycles after the read.
        for (int c = 0; c < 9; c++) begin
            smp();
            check("seq_valid", 32'(instr_valid), 32'((c % 3) == 2));
            check("seq_rden",  32'(mem_rd_en),   32'((c % 3) == 0));
            if ((c % 3) == 0) check("seq_addr", 32'(mem_addr), 32'(c / 3));
            if ((c % 3) == 2) begin
                check("seq_instr", 32'(instr),    32'(mem[c / 3]));
                check("seq_ipc",   32'(instr_pc), 32'(c / 3));
            end
            if (c == 2) begin
                check("wrap_valid0", 32'(instr_valid2), 32'd1);
                check("wrap_ipc0",   32'(instr_pc2),    32'hFFFF);
                check("wrap_instr0", 32'(instr2),       32'h7E57);
            end
            if (c == 5) begin
                check("wrap_valid1", 32'(instr_valid2), 32'd1);
                check("wrap_ipc1",   32'(instr_pc2),    32'h0000);
                check("wrap_instr1", 32'(instr2),       32'h5103);
            end
            next();
        end
        fetch_en = 1'b0;
        instr_ready = 1'b0;
        smp();
        check("seq_count", 32'(fetch_count), 32'd3);
        check("fe0_rden",  32'(mem_rd_en),   32'd0);

        // Redirect back to 0, then stall the handshake for 5 cycles.
        next();
        fetch_en = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 16'h0000;
        smp();
        check("redir_fetch_rden", 32'(mem_rd_en), 32'd0);
        next();
        redirect_valid = 1'b0;
        smp();
        check("stall_rden0", 32'(mem_rd_en), 32'd1);
        check("stall_addr0", 32'(mem_addr),  32'h0);
        next();
        fetch_en = 1'b0;
        smp();
        check("stall_wait_valid", 32'(instr_valid), 32'd0);
        check("stall_wait_rden",  32'(mem_rd_en),   32'd0);
        for (int k = 0; k < 5; k++) begin
            next();
            smp();
            check("stall_valid", 32'(instr_valid), 32'd1);
            check("stall_instr", 32'(instr),       32'h5103);
            check("stall_ipc",   32'(instr_pc),    32'h0);
            check("stall_rden",  32'(mem_rd_en),   32'd0);
        end
        next();
        instr_ready = 1'b1;
        fetch_en = 1'b1;
        smp();
        check("stall_end_valid", 32'(instr_valid), 32'd1);
        next();
        instr_ready = 1'b0;
        smp();
        check("adv_valid", 32'(instr_valid), 32'd0);
        check("adv_rden",  32'(mem_rd_en),   32'd1);
        check("adv_addr",  32'(mem_addr),    32'h1);
        check("adv_count", 32'(fetch_count), 32'd4);

        // Redirect during WAIT drops the returning word.
        next();
        redirect_valid = 1'b1;
        redirect_pc = 16'h0040;
        smp();
        check("wredir_rden", 32'(mem_rd_en), 32'd0);
        next();
        redirect_valid = 1'b0;
        smp();
        check("wredir_valid", 32'(instr_valid), 32'd0);
        check("wredir_rden2", 32'(mem_rd_en),   32'd1);
        check("wredir_addr",  32'(mem_addr),    32'h40);
        check("wredir_count", 32'(fetch_count), 32'd4);
        next();
        smp();
        next();
        instr_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 16'h0010;

        // Handshake and redirect in the same HOLD cycle.
        smp();
        check("hsredir_valid", 32'(instr_valid), 32'd1);
        check("hsredir_instr", 32'(instr),       32'hA5A5);
        check("hsredir_ipc",   32'(instr_pc),    32'h40);
        next();
        redirect_valid = 1'b0;
        instr_ready = 1'b0;
        fetch_en = 1'b0;
        smp();
        check("hsredir_count", 32'(fetch_count), 32'd5);
        check("hsredir_addr",  32'(mem_addr),    32'h10);
        check("hsredir_vld0",  32'(instr_valid), 32'd0);

        // Redirect in HOLD without handshake drops the held word uncounted.
        next();
        fetch_en = 1'b1;
        smp();
        next();
        fetch_en = 1'b0;
        smp();
        next();
        redirect_valid = 1'b1;
        redirect_pc = 16'h0020;
        smp();
        check("hdrop_valid1", 32'(instr_valid), 32'd1);
        check("hdrop_instr",  32'(instr),       32'h1234);
        next();
        redirect_valid = 1'b0;
        fetch_en = 1'b1;
        smp();
        check("hdrop_valid0", 32'(instr_valid), 32'd0);
        check("hdrop_addr",   32'(mem_addr),    32'h20);
        check("hdrop_count",  32'(fetch_count), 32'd5);
        check("hdrop_rden",   32'(mem_rd_en),   32'd1);

        // Random phase against an architectural model: each accepted word must be
        // mem[pc]. The PC advances by one per acceptance, or jumps to any redirect target.
        exp_pc  = 16'h0020;
        exp_cnt = 16'd5;
        held    = 1'b0;
        h_instr = 16'h0;
        h_pc    = 16'h0;
        for (int i = 0; i < 3000; i++) begin
            next();
            fetch_en       = ($urandom_range(3) != 0);
            instr_ready    = 1'($urandom_range(1));
            redirect_valid = ($urandom_range(15) == 0);
            redirect_pc    = 16'($urandom);
            smp();
            if (held) begin
                check("rnd_hold_valid", 32'(instr_valid), 32'd1);
                check("rnd_hold_instr", 32'(instr),       32'(h_instr));
                check("rnd_hold_ipc",   32'(instr_pc),    32'(h_pc));
            end
            if (mem_rd_en) check("rnd_addr", 32'(mem_addr), 32'(exp_pc));
            if (redirect_valid) check("rnd_redir_rden", 32'(mem_rd_en), 32'd0);
            hs = instr_valid & instr_ready;
            if (hs) begin
                check("rnd_instr", 32'(instr),       32'(mem[exp_pc]));
                check("rnd_ipc",   32'(instr_pc),    32'(exp_pc));
                check("rnd_count", 32'(fetch_count), 32'(exp_cnt));
                exp_cnt = exp_cnt + 16'd1;
            end
            if (redirect_valid) exp_pc = redirect_pc;
            else if (hs)        exp_pc = exp_pc + 16'd1;
            held    = instr_valid & ~instr_ready & ~redirect_valid;
            h_instr = instr;
            h_pc    = instr_pc;
        end

        // Reset asserted during WAIT takes effect immediately and drops the in-flight read.
        next();
        redirect_valid = 1'b1;
        redirect_pc = 16'h0300;
        instr_ready = 1'b0;
        fetch_en = 1'b0;
        smp();
        check("rnd_final_count", 32'(fetch_count), 32'(exp_cnt));
        next();
        redirect_valid = 1'b0;
        fetch_en = 1'b1;
        smp();
        check("pre_rst_addr", 32'(mem_addr), 32'h300);
        next();
        reset = 1'b0;
        #1;
        check("arst_valid", 32'(instr_valid), 32'd0);
        check("arst_instr", 32'(instr),       32'h0);
        check("arst_ipc",   32'(instr_pc),    32'h0);
        check("arst_count", 32'(fetch_count), 32'd0);
        check("arst_rden",  32'(mem_rd_en),   32'd0);
        check("arst_addr",  32'(mem_addr),    32'h0);
        next();
        reset = 1'b1;
        instr_ready = 1'b1;
        smp();
        check("post_rst_rden", 32'(mem_rd_en), 32'd1);
        check("post_rst_addr", 32'(mem_addr),  32'h0);
        found = 1'b0;
        for (int k = 0; k < 6 && !found; k++) begin
            next();
            smp();
            found = instr_valid;
        end
        check("post_rst_seen",  32'(found),       32'd1);
        check("post_rst_instr", 32'(instr),       32'h5103);
        check("post_rst_ipc",   32'(instr_pc),    32'h0);
        check("post_rst_count", 32'(fetch_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Producer side of the controller's `instr[15:0]` input: owns the program counter and reads 16-bit instruction words from synchronous-read instruction memory (block RAM).
- Presents one instruction at a time to the controller FSM over a valid/ready handshake.
- Accepts PC redirects for branches and jumps from the controller.
- Sits between instruction memory and the controller/Regfile_ALU_Datapath.

Parameters:
- ADDR_W, 16, width of PC and memory word address.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- fetch_en  input  1  when 0, no new memory read is issued.
- mem_rd_en  output  1  memory read strobe.
- mem_addr  output  ADDR_W  word address of the read.
- mem_rdata  input  16  read data, valid the cycle after mem_rd_en.
- instr  output  16  held instruction word.
- instr_pc  output  ADDR_W  address instr was fetched from.
- instr_valid  output  1  instr/instr_pc are valid.
- instr_ready  input  1  controller accepts instr this cycle.
- redirect_valid  input  1  load new PC (branch/jump taken).
- redirect_pc  input  ADDR_W  redirect target.
- fetch_count  output  16  number of completed handshakes; wraps.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=FETCH, pc=RESET_PC.
  - instr=16'h0000, instr_pc=0, instr_valid=0, fetch_count=0.
  - mem_rd_en=0, mem_addr=RESET_PC.
  - A reset mid-operation drops any in-flight read.
- Registered state machine with three states:
  - FETCH:
    - mem_rd_en = fetch_en & ~redirect_valid (combinational); mem_addr = pc.
    - If the read is issued, go to WAIT; otherwise stay in FETCH.
  - WAIT:
    - mem_rd_en=0.
    - Capture instr<=mem_rdata and instr_pc<=pc, set instr_valid<=1, go to HOLD.
  - HOLD:
    - instr_valid=1; instr and instr_pc are stable until the handshake completes.
    - Handshake is instr_valid & instr_ready: pc<=pc+1, instr_valid<=0, fetch_count<=fetch_count+1, go to FETCH.
    - Without instr_ready, stay in HOLD.
- Throughput:
  - Minimum 3 cycles per instruction (FETCH, WAIT, HOLD with ready=1).
  - instr_valid rises 2 cycles after the FETCH cycle that issues the read.
- Redirect has priority in every state:
  - redirect_valid=1 sets pc<=redirect_pc and state<=FETCH next cycle.
  - In WAIT: the returning mem_rdata is discarded; instr_valid stays 0.
  - In HOLD without handshake: instr_valid<=0; the held instruction is dropped and not counted.
  - In HOLD with a simultaneous handshake: the handshake counts (fetch_count increments) and pc<=redirect_pc, not pc+1.
  - In FETCH: no read is issued that cycle.
- PC arithmetic:
  - pc+1 is modulo 2^ADDR_W; 2^ADDR_W-1 wraps to 0.
  - redirect_pc is used verbatim.
  - fetch_count wraps at 16'hFFFF to 0.
- fetch_en=0:
  - Affects only FETCH (holds, no read).
  - A read already issued still completes through WAIT and HOLD.
- instr_ready while instr_valid=0 has no effect.
- Contents of instr while instr_valid=0 are don't-care for the controller but must hold their last value (no glitching).

Test Plan:
- Reset release, fetch_en=1, memory[0..2]=16'h5103,16'h0152,16'hB2FF, instr_ready=1 -> instr_valid pulses with instr=5103/0152/B2FF at instr_pc 0/1/2, 3 cycles apart; fetch_count=3.
- Hold instr_ready=0 for 5 cycles in HOLD with instr=16'h5103 -> instr and instr_pc stable, mem_rd_en=0 throughout; ready=1 then advances pc to 1.
- redirect_valid=1, redirect_pc=16'h0040 during WAIT -> returning word discarded, next read at mem_addr=0x0040, fetch_count unchanged.
- Handshake and redirect_pc=16'h0010 in the same HOLD cycle -> fetch_count increments, next mem_addr=0x0010.
- RESET_PC=16'hFFFF, sequential fetch -> instr_pc=FFFF then 0000.
- Assert reset low during WAIT -> outputs immediately at reset values; after release, first read at RESET_PC.
